water_dispenser_ctrl: RTL and testbench

//  - Controls a water dispenser valve from two raw inputs: cup-present sensor (x) and dispense button (y).
//  - Valve output z is on only while both debounced inputs are 1, with an on-time limit.
//  - Sits between board-level switches/sensors and the valve driver; all outputs are registered.

---
 rtl/water_dispenser_pkg.sv | 19 +
 rtl/wd_sync_debounce.sv | 74 +++++++
 rtl/water_dispenser_ctrl.sv | 129 ++++++++++++
 tb/tb_water_dispenser_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/water_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// water_dispenser_pkg
// Shared definitions for the water dispenser controller:
//   - wd_state_e : controller FSM state encoding (IDLE, DISPENSE, LOCKOUT)
//   - DEF_*      : default parameter values used by the top level
// -----------------------------------------------------------------------------
package water_dispenser_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // valve closed, waiting for cup + button
        DISPENSE = 2'd1,  // valve open, on-time being counted
        LOCKOUT  = 2'd2   // on-time limit hit, waiting for button release
    } wd_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_MAX_ON_CYCLES   = 1000;
    localparam int DEF_CNT_W           = 16;

endpackage : water_dispenser_pkg

// File: rtl/wd_sync_debounce.sv
// -----------------------------------------------------------------------------
// wd_sync_debounce
// Brings one raw asynchronous switch/sensor into the clk domain through a
// 2-flop synchronizer, then debounces it: the accepted value only changes
// after the synchronized value has disagreed with it for DEBOUNCE_CYCLES
// consecutive cycles. Any agreeing cycle restarts the count.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   rst    in  1  asynchronous active-high reset
//   raw_i  in  1  raw input, asynchronous to clk
//   db_o   out 1  debounced, clk-synchronous value (0 after reset)
// -----------------------------------------------------------------------------
module wd_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchronizer: raw_i is only ever observed through sync2_q.
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of its source; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count disagreeing cycles, flip on the last one.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule : wd_sync_debounce

// File: rtl/water_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// water_dispenser_ctrl
// Drives a water valve from a cup-present sensor (x) and a dispense button (y).
// Both inputs are synchronized and debounced; the valve opens while both
// debounced inputs are 1, and is forced shut (LOCKOUT) once it has been open
// for MAX_ON_CYCLES consecutive cycles. LOCKOUT is left only when the button
// is released, so a held button cannot restart dispensing.
// z and timeout are registered decodes of the next FSM state.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   x        in  1  raw cup-present sensor (1 = cup in place), async to clk
//   y        in  1  raw dispense button (1 = pressed), async to clk
//   z        out 1  valve enable (1 = water flows)
//   timeout  out 1  1 while in LOCKOUT
// -----------------------------------------------------------------------------
module water_dispenser_ctrl
    import water_dispenser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    output logic z,
    output logic timeout
);

    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MAX_ON_CYCLES - 1);

    logic             xd;
    logic             yd;
    logic             both;

    wd_state_e        state_q;
    wd_state_e        state_d;
    logic [CNT_W-1:0] on_cnt_q;
    logic [CNT_W-1:0] on_cnt_d;
    logic             z_q;
    logic             z_d;
    logic             timeout_q;
    logic             timeout_d;

    wd_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_x (
        .clk   (clk),
        .rst   (rst),
        .raw_i (x),
        .db_o  (xd)
    );

    wd_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_y (
        .clk   (clk),
        .rst   (rst),
        .raw_i (y),
        .db_o  (yd)
    );

    assign both = xd & yd;

    // State, on-time counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            on_cnt_q  <= '0;
            z_q       <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            on_cnt_q  <= on_cnt_d;
            z_q       <= z_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic. The on-counter holds the number of DISPENSE cycles
    // already completed; it stops at ON_LAST, so it can never wrap.
    always_comb begin
        state_d  = state_q;
        on_cnt_d = on_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (both) begin
                    state_d  = DISPENSE;
                    on_cnt_d = '0;
                end
            end
            DISPENSE: begin
                // Losing cup or button wins over the on-time limit.
                if (!both) begin
                    state_d = IDLE;
                end else if (on_cnt_q >= ON_LAST) begin
                    state_d = LOCKOUT;
                end else begin
                    on_cnt_d = on_cnt_q + 1'b1;
                end
            end
            LOCKOUT: begin
                // Only a button release rearms; the cup sensor is ignored.
                if (!yd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the
    // state register rather than one cycle later.
    always_comb begin
        z_d       = (state_d == DISPENSE);
        timeout_d = (state_d == LOCKOUT);
    end

    assign z       = z_q;
    assign timeout = timeout_q;

endmodule : water_dispenser_ctrl

// File: tb/tb_water_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_water_dispenser_ctrl
// Directed scenarios plus randomized input sequences for water_dispenser_ctrl
// (DEBOUNCE_CYCLES=4, MAX_ON_CYCLES=20, 10 ns clock). A behavioural model
// tracks raw-input history, debounced values and dispense mode; z and timeout
// are compared against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_water_dispenser_ctrl;
    import water_dispenser_pkg::*;

    localparam int DB    = 4;
    localparam int MAXON = 20;
    localparam int LAT   = 2 + DB + 1;

    localparam int M_IDLE = 0;
    localparam int M_DISP = 1;
    localparam int M_LOCK = 2;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic y;
    logic z;
    logic timeout;

    int n_checks = 0;
    int n_errors = 0;

    water_dispenser_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_ON_CYCLES   (MAXON),
        .CNT_W           (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .z       (z),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Raw samples reach the logic two edges late; an input is accepted once
    // the last DB synchronized samples all disagree with the current value.
    bit xq[$];
    bit yq[$];
    bit xs_h[$];
    bit ys_h[$];
    bit m_xd;
    bit m_yd;
    bit m_z;
    bit m_to;
    int m_mode;
    int m_on;   // cycles the valve has been (or will be) open in this run

    function automatic bit settle(input bit acc, input bit h[$]);
        if (h.size() < DB) return acc;
        foreach (h[i]) begin
            if (h[i] == acc) return acc;
        end
        return !acc;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            xq = '{1'b0, 1'b0};
            yq = '{1'b0, 1'b0};
            xs_h.delete();
            ys_h.delete();
            m_xd   = 1'b0;
            m_yd   = 1'b0;
            m_mode = M_IDLE;
            m_on   = 0;
            m_z    = 1'b0;
            m_to   = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_xd && m_yd) begin
                        m_mode = M_DISP;
                        m_on   = 1;
                    end
                end
                M_DISP: begin
                    if (!(m_xd && m_yd)) m_mode = M_IDLE;
                    else if (m_on == MAXON) m_mode = M_LOCK;
                    else m_on++;
                end
                default: begin
                    if (!m_yd) m_mode = M_IDLE;
                end
            endcase
            m_z  = (m_mode == M_DISP);
            m_to = (m_mode == M_LOCK);

            xs_h.push_back(xq.pop_front());
            ys_h.push_back(yq.pop_front());
            xq.push_back(x);
            yq.push_back(y);
            if (xs_h.size() > DB) void'(xs_h.pop_front());
            if (ys_h.size() > DB) void'(ys_h.pop_front());
            m_xd = settle(m_xd, xs_h);
            m_yd = settle(m_yd, ys_h);
        end
    end

    always @(negedge clk) begin
        check("model_z", z, m_z);
        check("model_timeout", timeout, m_to);
    end

    // -------------------------------------------------------------- helpers
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count rising edges until the selected output (0=z, 1=timeout) equals
    // val; returns -1 if it never does within max_cyc.
    task automatic wait_for(input int which, input logic val, input int max_cyc, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            cycle();
            s = (which == 0) ? z : timeout;
            if (s === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic go_idle();
        x = 1'b0;
        y = 1'b0;
        repeat (15) cycle();
    endtask

    // ---------------------------------------------------------------- tests
    initial begin
        int n;
        int hi;
        bit seen;
        bit dropped;

        rst = 1'b1;
        x   = 1'b0;
        y   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_z", z, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", u_dut.state_q, IDLE);
        rst = 1'b0;
        repeat (5) cycle();

        // 1. Truth table
        for (int p = 0; p < 3; p++) begin
            x = p[1];
            y = p[0];
            repeat (50) cycle();
            check($sformatf("t1_z_%0d%0d", p[1], p[0]), z, 0);
        end
        x = 1'b1;
        y = 1'b1;
        wait_for(0, 1'b1, 30, n);
        check("t1_rise_latency", n, LAT);
        repeat (5) cycle();
        check("t1_z_11", z, 1);
        go_idle();

        // 2. Short glitch on the button
        x = 1'b1;
        repeat (15) cycle();
        y = 1'b1;
        repeat (DB - 1) cycle();
        y = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            cycle();
            if (z || timeout) seen = 1'b1;
        end
        check("t2_glitch", seen, 0);
        go_idle();

        // 3. Cup removed mid-dispense
        x = 1'b1;
        y = 1'b1;
        wait_for(0, 1'b1, 30, n);
        check("t3_rise_latency", n, LAT);
        repeat (5) cycle();
        x = 1'b0;
        wait_for(0, 1'b0, 30, n);
        check("t3_fall_latency", n, LAT);
        check("t3_state", u_dut.state_q, IDLE);
        check("t3_timeout", timeout, 0);
        go_idle();

        // 4. On-time limit and rearm
        x  = 1'b1;
        y  = 1'b1;
        hi = 0;
        repeat (100) begin
            cycle();
            if (z) hi++;
        end
        check("t4_on_cycles", hi, MAXON);
        check("t4_z_locked", z, 0);
        check("t4_timeout", timeout, 1);
        y = 1'b0;
        wait_for(1, 1'b0, 30, n);
        check("t4_release_latency", n, LAT);
        y = 1'b1;
        wait_for(0, 1'b1, 30, n);
        check("t4_repress_latency", n, LAT);
        go_idle();

        // 5. Reset mid-dispense
        x = 1'b1;
        y = 1'b1;
        wait_for(0, 1'b1, 30, n);
        check("t5_rise_latency", n, LAT);
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1 check("t5_async_clear", z, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_for(0, 1'b1, 30, n);
        check("t5_recover_latency", n, LAT);
        go_idle();

        // 6. Simultaneous rise: first z=1 at exactly LAT, then steady
        x = 1'b1;
        y = 1'b1;
        wait_for(0, 1'b1, 30, n);
        check("t6_rise_latency", n, LAT);
        dropped = 1'b0;
        repeat (5) begin
            cycle();
            if (!z) dropped = 1'b1;
        end
        check("t6_steady", dropped, 0);
        go_idle();

        // Randomized segments, checked by the model on every cycle
        for (int s = 0; s < 80; s++) begin
            x = 1'($urandom_range(0, 1));
            y = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 30)) cycle();
        end
        go_idle();
        check("end_z", z, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_water_dispenser_ctrl
